// File: rtl/ram_io_responder.sv
// ram_io_responder
// Memory-side responder for a byte-wide CPU memory bus. Holds a byte RAM with
// one-cycle registered read data, and an I/O window at 0x30000:
//   0x30000 write : push byte into the TX FIFO (dropped + sticky overflow when full)
//   0x30004 write : set sticky sim_halt
//   0x30004 read  : {6'b0, io_overflow, fifo_empty}
//   other I/O     : writes ignored, reads return 0x00
// The TX FIFO drains over a ready/valid byte port, paced so that successive
// pops are at least TX_DIVIDER cycles apart.
//
// Ports:
//   i_clk              clock, all state updates on the rising edge
//   i_rst              synchronous active-low reset
//   i_mem_a[31:0]      byte address (bits above 17 ignored)
//   i_mem_dout[7:0]    write data from the controller
//   i_mem_wr           1 = write, 0 = read
//   o_mem_din[7:0]     registered read data (held across write cycles)
//   o_io_buffer_full   registered "TX FIFO cannot guarantee space" flag
//   o_tx_valid         tx byte valid
//   o_tx_data[7:0]     head byte of the TX FIFO
//   i_tx_ready         sink accepts the byte when high together with o_tx_valid
//   o_io_overflow      sticky, a TX write was dropped
//   o_sim_halt         sticky, 0x30004 was written
module ram_io_responder #(
  parameter int    ADDR_WIDTH  = 17,
  parameter int    FIFO_DEPTH  = 8,
  parameter int    FULL_MARGIN = 2,
  parameter int    TX_DIVIDER  = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_mem_a,
  input  logic [7:0]  i_mem_dout,
  input  logic        i_mem_wr,
  output logic [7:0]  o_mem_din,
  output logic        o_io_buffer_full,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_io_overflow,
  output logic        o_sim_halt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PACE_W = (TX_DIVIDER > 1) ? $clog2(TX_DIVIDER) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  FULL_THRESH = CNT_W'(FIFO_DEPTH - FULL_MARGIN);
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(TX_DIVIDER - 1);

  localparam logic [17:0] TX_ADDR   = 18'h3_0000;
  localparam logic [17:0] HALT_ADDR = 18'h3_0004;

  // Storage
  logic [7:0]        r_ram  [0:(1 << ADDR_WIDTH)-1];
  logic [7:0]        r_fifo [0:FIFO_DEPTH-1];

  // State and registered outputs
  logic [7:0]        r_mem_din;
  logic              r_io_buffer_full;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_io_overflow;
  logic              r_sim_halt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PACE_W-1:0] r_pace;

  // Decode and FIFO control
  logic              w_is_io;
  logic              w_tx_wr;
  logic              w_halt_wr;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic [7:0]        w_io_rd_data;

  // Next-state values
  logic [CNT_W-1:0]  w_count_next;
  logic [CNT_W-1:0]  w_count_after_pop;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [PTR_W-1:0]  w_wr_ptr_next;
  logic [PACE_W-1:0] w_pace_next;
  logic [7:0]        w_head_next;

  // Address bits above the decoded range have no effect.
  logic              w_unused;
  assign w_unused = &{1'b0, i_mem_a[31:18]};

  assign w_is_io      = (i_mem_a[17:16] == 2'b11);
  assign w_ram_idx    = i_mem_a[ADDR_WIDTH-1:0];
  assign w_tx_wr      = i_mem_wr && (i_mem_a[17:0] == TX_ADDR);
  assign w_halt_wr    = i_mem_wr && (i_mem_a[17:0] == HALT_ADDR);
  assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
  assign w_fifo_full  = (r_count == DEPTH_C);
  assign w_push       = w_tx_wr && !w_fifo_full;
  assign w_drop       = w_tx_wr && w_fifo_full;
  // r_tx_valid already encodes "not empty and pacing expired".
  assign w_pop        = r_tx_valid && i_tx_ready;

  // I/O read data mux: only the status register returns anything non-zero.
  always_comb begin
    w_io_rd_data = 8'h00;
    case (i_mem_a[17:0])
      HALT_ADDR: w_io_rd_data = {6'b00_0000, r_io_overflow, w_fifo_empty};
      default:   w_io_rd_data = 8'h00;
    endcase
  end

  // FIFO occupancy, pointer and pacing next-state.
  always_comb begin
    w_count_next      = r_count;
    w_count_after_pop = r_count;
    w_rd_ptr_next     = r_rd_ptr;
    w_wr_ptr_next     = r_wr_ptr;
    w_pace_next       = r_pace;

    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase

    if (w_pop) begin
      w_count_after_pop = r_count - CNT_W'(1);
      w_rd_ptr_next     = r_rd_ptr + PTR_W'(1);
    end else begin
      w_count_after_pop = r_count;
      w_rd_ptr_next     = r_rd_ptr;
    end

    if (w_push) begin
      w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
    end else begin
      w_wr_ptr_next = r_wr_ptr;
    end

    if (w_pop) begin
      w_pace_next = PACE_RELOAD;
    end else if (r_pace != {PACE_W{1'b0}}) begin
      w_pace_next = r_pace - PACE_W'(1);
    end else begin
      w_pace_next = r_pace;
    end
  end

  // Head byte after this edge. When the FIFO would otherwise be empty the
  // incoming byte becomes the head directly, since it is not in storage yet.
  always_comb begin
    w_head_next = r_fifo[w_rd_ptr_next];
    if (w_push && (w_count_after_pop == {CNT_W{1'b0}})) begin
      w_head_next = i_mem_dout;
    end else begin
      w_head_next = r_fifo[w_rd_ptr_next];
    end
  end

  // RAM write port; bus writes are ignored while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (i_rst && i_mem_wr && !w_is_io) begin
      r_ram[w_ram_idx] <= i_mem_dout;
    end
  end

  // Registered read data; write cycles hold the previous value.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mem_din <= 8'h00;
    end else if (!i_mem_wr) begin
      r_mem_din <= w_is_io ? w_io_rd_data : r_ram[w_ram_idx];
    end
  end

  // TX FIFO storage write.
  always_ff @(posedge i_clk) begin
    if (i_rst && w_push) begin
      r_fifo[r_wr_ptr] <= i_mem_dout;
    end
  end

  // FIFO pointers, count and pacing counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_pace   <= {PACE_W{1'b0}};
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_pace   <= w_pace_next;
    end
  end

  // TX port and throttle flag, registered from next-state so they line up
  // with the count and pacing state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tx_valid       <= 1'b0;
      r_tx_data        <= 8'h00;
      r_io_buffer_full <= 1'b0;
    end else begin
      r_tx_valid       <= (w_count_next != {CNT_W{1'b0}}) && (w_pace_next == {PACE_W{1'b0}});
      r_tx_data        <= w_head_next;
      r_io_buffer_full <= (w_count_next >= FULL_THRESH);
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_io_overflow <= 1'b0;
      r_sim_halt    <= 1'b0;
    end else begin
      r_io_overflow <= r_io_overflow | w_drop;
      r_sim_halt    <= r_sim_halt | w_halt_wr;
    end
  end

  assign o_mem_din        = r_mem_din;
  assign o_io_buffer_full = r_io_buffer_full;
  assign o_tx_valid       = r_tx_valid;
  assign o_tx_data        = r_tx_data;
  assign o_io_overflow    = r_io_overflow;
  assign o_sim_halt       = r_sim_halt;

endmodule

// File: tb/tb_ram_io_responder.sv
// Testbench for ram_io_responder: directed bus traffic; expected read data and
// expected TX bytes are queued at issue time and checked by separate monitors.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        io_overflow;
  logic        sim_halt;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        chk_rd = 1'b0;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_q [$];
  logic [7:0]  tx_q [$];
  int          pop_cyc [$];

  always #5 clk = ~clk;

  ram_io_responder #(
    .ADDR_WIDTH (17),
    .FIFO_DEPTH (8),
    .FULL_MARGIN(2),
    .TX_DIVIDER (4),
    .INIT_FILE  ("")
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_mem_a         (mem_a),
    .i_mem_dout      (mem_dout),
    .i_mem_wr        (mem_wr),
    .o_mem_din       (mem_din),
    .o_io_buffer_full(io_buffer_full),
    .o_tx_valid      (tx_valid),
    .o_tx_data       (tx_data),
    .i_tx_ready      (tx_ready),
    .o_io_overflow   (io_overflow),
    .o_sim_halt      (sim_halt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter and read-issued pipeline flag.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= chk_rd && rst;
  end

  // Read-data monitor: one cycle after a checked read, compare with the queue.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", mem_din);
      end else begin
        check("mem_din", {24'h0, mem_din}, {24'h0, rd_q.pop_front()});
      end
    end
  end

  // TX monitor: every accepted byte is compared with the next expected byte.
  always @(posedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      pop_cyc.push_back(cyc);
      if (tx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no pop", tx_data);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  task automatic step_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_dout = d; mem_wr = 1'b1; chk_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic step_rd(input logic [31:0] a, input logic [7:0] exp);
    mem_a = a; mem_wr = 1'b0; chk_rd = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    mem_a = 32'h0; mem_wr = 1'b0; chk_rd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_q.push_back(d);
    step_wr(32'h0003_0000, d);
  endtask

  task automatic do_reset(input logic [31:0] a, input logic [7:0] d);
    rst = 1'b0; mem_a = a; mem_dout = d; mem_wr = 1'b1; chk_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_wr = 1'b0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    idle(0);
    while (tx_q.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    check("drain_done", tx_q.size(), 0);
  endtask

  task automatic check_spacing(input string name, input int n);
    check({name, "_pops"}, pop_cyc.size(), n);
    for (int i = 1; i < pop_cyc.size(); i++) begin
      check({name, "_gap"}, pop_cyc[i] - pop_cyc[i-1], 4);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_din", mem_din, 0);
    check("rst_full", io_buffer_full, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", io_overflow, 0);
    check("rst_halt", sim_halt, 0);
    rst = 1'b1;

    // RAM write/read, aliasing, high bits ignored, hold on write
    step_wr(32'h0000_1234, 8'hA5);
    step_rd(32'h0000_1234, 8'hA5);
    step_rd(32'h0002_1234, 8'hA5);
    step_rd(32'hFFFE_1234, 8'hA5);
    step_wr(32'h0000_0005, 8'h11);
    check("din_hold_on_wr", mem_din, 8'hA5);
    step_rd(32'h0000_0005, 8'h11);

    // Back-to-back pipelined reads
    step_wr(32'h100, 8'h78);
    step_wr(32'h101, 8'h56);
    step_wr(32'h102, 8'h34);
    step_wr(32'h103, 8'h12);
    step_rd(32'h103, 8'h12);
    step_rd(32'h102, 8'h34);
    step_rd(32'h101, 8'h56);
    step_rd(32'h100, 8'h78);

    // Fill the FIFO with the sink stalled, then overflow it
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_tx(8'h10 + 8'(i));
    check("full_at_5", io_buffer_full, 0);
    push_tx(8'h15);
    check("full_at_6", io_buffer_full, 1);
    check("tx_valid_stalled", tx_valid, 1);
    check("tx_head_stalled", tx_data, 8'h10);
    push_tx(8'h16);
    push_tx(8'h17);
    check("no_overflow_at_8", io_overflow, 0);
    step_wr(32'h0003_0000, 8'h18);
    check("overflow_set", io_overflow, 1);
    step_rd(32'h0003_0004, 8'h02);
    step_rd(32'h0003_0000, 8'h00);
    step_rd(32'h0003_0008, 8'h00);
    pop_cyc.delete();
    tx_ready = 1'b1;
    drain(100);
    check_spacing("drain8", 8);
    check("full_after_drain", io_buffer_full, 0);
    check("valid_after_drain", tx_valid, 0);
    check("overflow_sticky", io_overflow, 1);

    tx_ready = 1'b0;
    do_reset(32'h0, 8'h00);
    check("overflow_cleared", io_overflow, 0);

    // Paced drain of three bytes
    tx_ready = 1'b1;
    pop_cyc.delete();
    check("valid_before_push", tx_valid, 0);
    push_tx(8'h41);
    check("first_valid", tx_valid, 1);
    check("first_data", tx_data, 8'h41);
    push_tx(8'h42);
    push_tx(8'h43);
    drain(40);
    check_spacing("pace", 3);
    check("valid_falls", tx_valid, 0);
    step_rd(32'h0003_0004, 8'h01);

    // Simultaneous push/pop at count 5, then wrap with mixed traffic
    tx_ready = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) push_tx(8'h50 + 8'(i));
    tx_ready = 1'b1;
    push_tx(8'h55);
    tx_ready = 1'b0;
    check("full_pushpop_5", io_buffer_full, 0);
    push_tx(8'h56);
    check("full_at_6_again", io_buffer_full, 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_tx(8'h60 + 8'(i));
      idle(3);
    end
    check("no_overflow_mixed", io_overflow, 0);
    drain(100);

    // Reset mid-transfer with halt set; RAM survives, bus ignored in reset
    tx_ready = 1'b0;
    step_wr(32'h2000, 8'h5A);
    for (int i = 0; i < 4; i++) step_wr(32'h0003_0000, 8'h81 + 8'(i));
    check("queued_valid", tx_valid, 1);
    step_wr(32'h0003_0004, 8'h00);
    check("halt_set", sim_halt, 1);
    do_reset(32'h2000, 8'hFF);
    check("rst2_mem_din", mem_din, 0);
    check("rst2_full", io_buffer_full, 0);
    check("rst2_tx_valid", tx_valid, 0);
    check("rst2_tx_data", tx_data, 0);
    check("rst2_overflow", io_overflow, 0);
    check("rst2_halt", sim_halt, 0);
    step_rd(32'h0003_0004, 8'h01);
    step_rd(32'h2000, 8'h5A);
    step_rd(32'h1234, 8'hA5);
    tx_ready = 1'b1;
    idle(6);
    check("empty_after_rst", tx_valid, 0);

    idle(2);
    check("rd_q_drained", rd_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
